mmio_gpio_ctrl: RTL and testbench

- Parametrised memory-mapped GPIO controller on the Risc32 io bus (io_address / io_write_value / io_read_value / io_write_en / io_read_en / io_data_size).
- Replaces the ad-hoc switch/button/LED decode at top level.
- Adds:
  - input synchronisation and debounce
  - sticky button edge capture with write-1-to-clear
  - readable LED register
  - byte, half and word write lanes
- Instantiated once at top level, between Risc32 and the board pins.

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_debounce.sv | 33 +++
 rtl/mmio_gpio_ctrl.sv | 111 +++++++++++
 tb/tb_mmio_gpio_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register map, access-size codes and byte-lane helpers for the MMIO GPIO controller.
package gpio_pkg;

  localparam logic [2:0] REG_SW       = 3'd0;
  localparam logic [2:0] REG_BTN      = 3'd1;
  localparam logic [2:0] REG_EDGE     = 3'd2;
  localparam logic [2:0] REG_LED      = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK = 3'd4;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  // Unknown size codes fall back to a full-word access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr;
      SZ_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus two-sample agreement debounce, sampled on a shared prescaler tick.
module gpio_debounce #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sync1, sync2, samp, agree;

  assign agree = ~(sync2 ^ samp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      samp  <= '0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (tick) begin
        samp <= sync2;
        // A bit moves only when two consecutive tick samples agree.
        dout <= (dout & ~agree) | (sync2 & agree);
      end
    end
  end

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller on the Risc32 io bus: debounced switches/buttons, W1C edge capture, LED register.
// Optional macro GPIO_IRQ_EN adds an IRQ_MASK register and a registered irq output.
module mmio_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int SW_W     = 16,
  parameter int BTN_W    = 5,
  parameter int LED_W    = 16,
  parameter int DEB_TICK = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      io_address,
  input  logic [31:0]      io_write_value,
  input  logic             io_write_en,
  input  logic             io_read_en,
  input  logic [2:0]       io_data_size,
  output logic [31:0]      io_read_value,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [LED_W-1:0] led
`ifdef GPIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int DEB_CW = $clog2(DEB_TICK);

  logic [DEB_CW-1:0] pcnt;
  logic              tick;
  logic [SW_W-1:0]   sw_db;
  logic [BTN_W-1:0]  btn_db, btn_prev, edge_q, edge_clr;
  logic [2:0]        reg_idx;
  logic [31:0]       wmask, wbits, rdata;
  logic              wr_led, wr_edge;

  assign tick = (pcnt == DEB_CW'(DEB_TICK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  gpio_debounce #(.W(SW_W)) u_sw_deb (
    .clk(clk), .rst_n(rst_n), .tick(tick), .din(sw), .dout(sw_db)
  );

  gpio_debounce #(.W(BTN_W)) u_btn_deb (
    .clk(clk), .rst_n(rst_n), .tick(tick), .din(btn), .dout(btn_db)
  );

  // Write data is lane-aligned on the bus; only the addressed lanes pass.
  assign reg_idx  = io_address[4:2];
  assign wmask    = lane_bits(lane_mask(io_data_size, io_address[1:0]));
  assign wbits    = io_write_value & wmask;
  assign wr_led   = io_write_en && (reg_idx == REG_LED);
  assign wr_edge  = io_write_en && (reg_idx == REG_EDGE);
  assign edge_clr = wr_edge ? wbits[BTN_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      edge_q   <= '0;
      led      <= '0;
    end else begin
      btn_prev <= btn_db;
      // A new rising edge beats a simultaneous software clear.
      edge_q   <= (edge_q & ~edge_clr) | (btn_db & ~btn_prev);
      if (wr_led)
        led <= (led & ~wmask[LED_W-1:0]) | wbits[LED_W-1:0];
    end
  end

`ifdef GPIO_IRQ_EN
  logic [BTN_W-1:0] irq_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (io_write_en && (reg_idx == REG_IRQ_MASK))
        irq_mask <= (irq_mask & ~wmask[BTN_W-1:0]) | wbits[BTN_W-1:0];
      irq <= |(edge_q & irq_mask);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_SW:       rdata = 32'(sw_db);
      REG_BTN:      rdata = 32'(btn_db);
      REG_EDGE:     rdata = 32'(edge_q);
      REG_LED:      rdata = 32'(led);
`ifdef GPIO_IRQ_EN
      REG_IRQ_MASK: rdata = 32'(irq_mask);
`endif
      default:      rdata = '0;
    endcase
  end

  // Sampled from pre-write state, so a same-cycle read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          io_read_value <= '0;
    else if (io_read_en) io_read_value <= rdata;
  end

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Directed bench for mmio_gpio_ctrl with DEB_TICK=4; covers GPIO_IRQ_EN when that macro is defined.
module tb_mmio_gpio_ctrl;

  localparam int SW_W = 16, BTN_W = 5, LED_W = 16, DEB_TICK = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      io_address, io_write_value, io_read_value;
  logic             io_write_en, io_read_en;
  logic [2:0]       io_data_size;
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic [LED_W-1:0] led;
`ifdef GPIO_IRQ_EN
  logic             irq;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] rv;
  int pcnt;

  always #5 clk = ~clk;

  mmio_gpio_ctrl #(.SW_W(SW_W), .BTN_W(BTN_W), .LED_W(LED_W), .DEB_TICK(DEB_TICK)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_data_size(io_data_size), .io_read_value(io_read_value),
    .sw(sw), .btn(btn), .led(led)
`ifdef GPIO_IRQ_EN
    , .irq(irq)
`endif
  );

  // Reference phase of the free-running debounce prescaler (0..DEB_TICK-1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= 0;
    else        pcnt <= (pcnt == DEB_TICK - 1) ? 0 : pcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    io_address = a; io_write_value = d; io_data_size = s; io_write_en = 1'b1;
    @(posedge clk); #1;
    io_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    io_address = a; io_data_size = 3'd2; io_read_en = 1'b1;
    @(posedge clk); #1;
    io_read_en = 1'b0;
    v = io_read_value;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after a tick edge (prescaler back at 0).
  task automatic align_tick();
    do begin
      @(posedge clk); #1;
    end while (pcnt != 0);
  endtask

  initial begin
    rst_n = 1'b0; io_address = '0; io_write_value = '0; io_write_en = 1'b0;
    io_read_en = 1'b0; io_data_size = 3'd2; sw = 16'hFFFF; btn = '0;

    cycles(3);
    check("reset_led", 32'(led), 32'h0);
    check("reset_rdata", io_read_value, 32'h0);
    rst_n = 1'b1;

    rd(32'h00, rv); check("sw_early", rv, 32'h0);
    cycles(20);
    rd(32'h00, rv); check("sw_settled", rv, 32'h0000FFFF);

    // Two-cycle glitch on btn[0] must not survive the debounce.
    btn[0] = 1'b1; cycles(2); btn[0] = 1'b0;
    cycles(12);
    rd(32'h04, rv); check("glitch_btn", rv, 32'h0);
    rd(32'h08, rv); check("glitch_edge", rv, 32'h0);

    btn[0] = 1'b1; cycles(12);
    rd(32'h04, rv); check("hold_btn", rv, 32'h1);
    rd(32'h08, rv); check("hold_edge", rv, 32'h1);

    // LED write lanes; data is placed in its byte lane on the bus.
    wr(32'h0C, 32'h00001234, 3'd2);
    wr(32'h0D, 32'h0000AB00, 3'd0);
    rd(32'h0C, rv); check("led_byte", rv, 32'h0000AB34);
    wr(32'h0E, 32'hBEEF0000, 3'd1);
    rd(32'h0C, rv); check("led_half_hi_discard", rv, 32'h0000AB34);
    wr(32'h0D, 32'h0000CDEF, 3'd1);
    rd(32'h0C, rv); check("led_half_lo", rv, 32'h0000CDEF);

    wr(32'h14, 32'hFFFFFFFF, 3'd2);
    rd(32'h14, rv); check("reserved_rd", rv, 32'h0);
`ifndef GPIO_IRQ_EN
    wr(32'h10, 32'hFFFFFFFF, 3'd2);
    rd(32'h10, rv); check("idx4_absent", rv, 32'h0);
`endif

    // Build EDGE=00011 with btn[0] debounced low again.
    btn[1] = 1'b1; btn[0] = 1'b0; cycles(14);
    rd(32'h04, rv); check("btn_pre_collision", rv, 32'h2);
    // Raw step right after a tick: debounced rise at tick+8, edge sets at tick+9.
    align_tick();
    btn[0] = 1'b1;
    cycles(8);
    wr(32'h08, 32'h1, 3'd2);
    rd(32'h08, rv); check("w1c_collision", rv, 32'h3);
    wr(32'h08, 32'h3, 3'd2);
    rd(32'h08, rv); check("w1c_clear", rv, 32'h0);

    // Same-cycle read and write of LED returns the old value.
    wr(32'h0C, 32'h000000FF, 3'd2);
    io_address = 32'h0C; io_write_value = 32'h5555; io_data_size = 3'd2;
    io_write_en = 1'b1; io_read_en = 1'b1;
    @(posedge clk); #1;
    io_write_en = 1'b0; io_read_en = 1'b0;
    check("rw_same_old", io_read_value, 32'h000000FF);
    rd(32'h0C, rv); check("rw_same_new", rv, 32'h00005555);

`ifdef GPIO_IRQ_EN
    wr(32'h10, 32'h4, 3'd2);
    rd(32'h10, rv); check("irq_mask_rd", rv, 32'h4);
    align_tick();
    btn[2] = 1'b1;
    cycles(9);
    check("irq_before", 32'(irq), 32'h0);
    rd(32'h08, rv); check("irq_edge2_set", rv, 32'h4);
    check("irq_asserted", 32'(irq), 32'h1);
    wr(32'h08, 32'h4, 3'd2);
    check("irq_hold_after_clr", 32'(irq), 32'h1);
    cycles(1);
    check("irq_dropped", 32'(irq), 32'h0);
    btn[1] = 1'b0; cycles(14);
    btn[1] = 1'b1; cycles(14);
    rd(32'h08, rv); check("irq_btn1_edge", rv, 32'h2);
    check("irq_masked_low", 32'(irq), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
